cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the console CPU. It steps the datapath through fetch, execute, optional data-memory access, and writeback. It gates the decoder's `reg_write`/`flags_write` intent into single-cycle write strobes and drives PC update and data-memory handshakes. It also provides run/single-step/stop control for the debug console. It sits between the combinational opcode decoder, the PC/IR registers, the register file, the flags register and the data-memory port.

---
 rtl/cpu_sequencer.sv | 117 +++++++++++
 tb/tb_cpu_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> [MEM] -> WB with run/step/stop
// control. Strobes are decoded from state plus decoder intent and forced low under reset.
module cpu_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic                 reg_write,
    input  logic                 flags_write,
    input  logic                 is_mem_access,
    input  logic                 dm_write,
    input  logic                 is_stop,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 rf_we,
    output logic                 flags_we,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic                 halted,
    output logic                 stopped,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_STOPPED
    } state_t;

    state_t state, state_nxt;
    logic   single, single_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HALT;
            single      <= 1'b0;
            instr_count <= '0;
        end else begin
            state  <= state_nxt;
            single <= single_nxt;
            if (state == S_WB)
                instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        single_nxt = single;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        rf_we      = 1'b0;
        flags_we   = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        case (state)
            S_HALT: begin
                if (run) begin
                    state_nxt  = S_FETCH;
                    single_nxt = 1'b0;
                end else if (step) begin
                    state_nxt  = S_FETCH;
                    single_nxt = 1'b1;
                end
            end
            S_FETCH: begin
                ir_load   = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_stop)
                    state_nxt = S_STOPPED;
                else if (is_mem_access || dm_write)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = dm_write;
                if (mem_ready)
                    state_nxt = S_WB;
            end
            S_WB: begin
                rf_we     = reg_write;
                flags_we  = flags_write;
                pc_load   = branch_taken;
                pc_inc    = !branch_taken;
                state_nxt = (run && !single) ? S_FETCH : S_HALT;
            end
            S_STOPPED: state_nxt = S_STOPPED;
            default:   state_nxt = S_HALT;
        endcase
        // Reset must silence every strobe in the very cycle it is sampled.
        if (rst) begin
            ir_load  = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            rf_we    = 1'b0;
            flags_we = 1'b0;
            dm_req   = 1'b0;
            dm_we    = 1'b0;
        end
    end

    assign halted  = (state == S_HALT) || (state == S_STOPPED);
    assign stopped = (state == S_STOPPED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: each instruction is expanded into its expected
// per-cycle strobe trace from the cycle rules, then compared cycle by cycle.
module tb_cpu_sequencer;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst, run, step, reg_write, flags_write, is_mem_access, dm_write, is_stop;
    logic branch_taken, mem_ready;
    logic ir_load, pc_inc, pc_load, rf_we, flags_we, dm_req, dm_we, halted, stopped;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    int cnt_m = 0;
    bit single_m = 1'b0;
    bit cont = 1'b0;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .reg_write(reg_write), .flags_write(flags_write),
        .is_mem_access(is_mem_access), .dm_write(dm_write), .is_stop(is_stop),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we),
        .flags_we(flags_we), .dm_req(dm_req), .dm_we(dm_we), .halted(halted),
        .stopped(stopped), .instr_count(instr_count)
    );

    // {ir_load, pc_inc, pc_load, rf_we, flags_we, dm_req, dm_we}
    function automatic logic [6:0] strobes();
        return {ir_load, pc_inc, pc_load, rf_we, flags_we, dm_req, dm_we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From HALT: present run/step for one cycle.
    task automatic launch(input bit r, input bit s);
        run = r; step = s; mem_ready = 1'($urandom);
        #1;
        total++;
        if (strobes() !== 7'b0 || halted !== 1'b1) begin
            bad++;
            $display("FAIL launch: strobes=%b halted=%b, want strobes=0000000 halted=1", strobes(), halted);
        end
        single_m = !r;
        tick();
        step = 1'b0;
    endtask

    // Runs one instruction starting in its FETCH cycle. run is 1 in cycles before drop_at.
    task automatic run_instr(input bit rw, input bit fw, input bit ld, input bit sw,
                             input bit stp, input bit br, input int waits,
                             input int drop_at, output bit cont_o);
        logic [6:0] exp_q[$];
        int  mem_last;
        bit  run_wb;
        exp_q.push_back(7'b1000000);
        exp_q.push_back(7'b0000000);
        if (!stp) begin
            if (ld || sw)
                for (int i = 0; i <= waits; i++) exp_q.push_back({5'b0, 1'b1, sw});
            exp_q.push_back({1'b0, !br, br, rw, fw, 2'b00});
        end
        mem_last = (!stp && (ld || sw)) ? 2 + waits : -1;
        reg_write = rw; flags_write = fw; is_mem_access = ld; dm_write = sw;
        is_stop = stp; branch_taken = br;
        run_wb = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            run  = (i < drop_at);
            step = 1'($urandom);
            if (i >= 2 && i < mem_last)  mem_ready = 1'b0;
            else if (i == mem_last)      mem_ready = 1'b1;
            else                         mem_ready = 1'($urandom);
            #1;
            total++;
            if (strobes() !== exp_q[i] || halted !== 1'b0) begin
                bad++;
                $display("FAIL instr_cyc%0d: strobes=%b halted=%b, want strobes=%b halted=0",
                         i, strobes(), halted, exp_q[i]);
            end
            if (i == exp_q.size() - 1) run_wb = run;
            tick();
        end
        step = 1'b0;
        if (!stp) cnt_m++;
        total++;
        if (instr_count !== CW'(cnt_m)) begin
            bad++;
            $display("FAIL instr_count: got %0d, want %0d", instr_count, CW'(cnt_m));
        end
        cont_o = !stp && run_wb && !single_m;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; step = 1'b1;
        reg_write = 1'b1; flags_write = 1'b1; is_mem_access = 1'b0; dm_write = 1'b0;
        is_stop = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        total++;
        if (strobes() !== 7'b0 || halted !== 1'b1 || stopped !== 1'b0 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL reset: strobes=%b halted=%b stopped=%b cnt=%0d, want 0000000 1 0 0",
                     strobes(), halted, stopped, instr_count);
        end
        rst = 1'b0; run = 1'b0; step = 1'b0; cnt_m = 0;
        #1;
    endtask

    task automatic test_add_run();
        launch(1'b1, 1'b0);
        run_instr(1, 1, 0, 0, 0, 0, 0, 99, cont);   // ADD, run held
        run_instr(0, 0, 0, 0, 0, 0, 0, 1, cont);    // NOP, FETCH back-to-back, run drops
        run = 1'b0;
        #1;
        total++;
        if (halted !== 1'b1 || strobes() !== 7'b0) begin
            bad++;
            $display("FAIL add_halt: halted=%b strobes=%b, want 1 0000000", halted, strobes());
        end
        tick();
    endtask

    task automatic test_mem();
        launch(1'b1, 1'b0);
        run_instr(1, 0, 1, 0, 0, 0, 3, 99, cont);   // LW, 3 wait cycles
        run_instr(0, 0, 0, 1, 0, 0, 2, 2, cont);    // SW, run drops in MEM
        #1;
        total++;
        if (halted !== 1'b1 || strobes() !== 7'b0) begin
            bad++;
            $display("FAIL mem_halt: halted=%b strobes=%b, want 1 0000000", halted, strobes());
        end
        tick();
    endtask

    task automatic test_branch_step();
        launch(1'b0, 1'b1);
        run_instr(0, 0, 0, 0, 0, 1, 0, 0, cont);    // JZ taken
        launch(1'b0, 1'b1);
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, cont);    // JZ not taken
        launch(1'b0, 1'b1);
        run_instr(1, 1, 0, 0, 0, 0, 0, 99, cont);   // single even with run raised mid-instr
        run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'($urandom);
            #1;
            total++;
            if (halted !== 1'b1 || strobes() !== 7'b0 || instr_count !== CW'(cnt_m)) begin
                bad++;
                $display("FAIL step_halt: halted=%b strobes=%b cnt=%0d, want 1 0000000 %0d",
                         halted, strobes(), instr_count, CW'(cnt_m));
            end
            tick();
        end
    endtask

    task automatic test_stop();
        launch(1'b1, 1'b0);
        run_instr(1, 1, 0, 0, 1, 0, 0, 99, cont);
        for (int c = 0; c < 5; c++) begin
            run = 1'($urandom); step = 1'($urandom); mem_ready = 1'($urandom);
            #1;
            total++;
            if (strobes() !== 7'b0 || halted !== 1'b1 || stopped !== 1'b1 || instr_count !== CW'(cnt_m)) begin
                bad++;
                $display("FAIL stopped: strobes=%b halted=%b stopped=%b cnt=%0d, want 0000000 1 1 %0d",
                         strobes(), halted, stopped, instr_count, CW'(cnt_m));
            end
            tick();
        end
        rst = 1'b1; run = 1'b0; step = 1'b0;
        tick();
        rst = 1'b0; cnt_m = 0;
        #1;
        total++;
        if (stopped !== 1'b0 || halted !== 1'b1 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL stop_clear: stopped=%b halted=%b cnt=%0d, want 0 1 0", stopped, halted, instr_count);
        end
        tick();
    endtask

    task automatic test_wrap();
        launch(1'b1, 1'b0);
        for (int k = 0; k < 16; k++)
            run_instr(1'($urandom), 1'($urandom), 0, 0, 0, 1'($urandom), 0, (k == 15) ? 0 : 99, cont);
        total++;
        if (instr_count !== 4'd0) begin
            bad++;
            $display("FAIL wrap: cnt=%0d, want 0", instr_count);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_rst_in_mem();
        launch(1'b1, 1'b0);
        reg_write = 1'b1; flags_write = 1'b0; is_mem_access = 1'b1; dm_write = 1'b0;
        is_stop = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        tick(); tick();                              // FETCH, EXEC
        #1;
        total++;
        if (dm_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mem_req: dm_req=%b, want 1", dm_req);
        end
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (strobes() !== 7'b0) begin
            bad++;
            $display("FAIL rst_mem_same: strobes=%b, want 0000000", strobes());
        end
        tick();
        rst = 1'b0; run = 1'b0; mem_ready = 1'b1; cnt_m = 0;
        #1;
        total++;
        if (strobes() !== 7'b0 || halted !== 1'b1 || instr_count !== 4'd0) begin
            bad++;
            $display("FAIL rst_mem_after: strobes=%b halted=%b cnt=%0d, want 0000000 1 0",
                     strobes(), halted, instr_count);
        end
        tick();
    endtask

    task automatic test_random();
        bit rw, fw, ld, sw, br, r;
        int kind, drop;
        cont = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!cont) begin
                r = 1'($urandom);
                launch(r, 1'b1);
            end
            kind = $urandom_range(0, 6);
            rw = 0; fw = 0; ld = 0; sw = 0; br = 0;
            case (kind)
                0: begin rw = 1; fw = 1; end
                1: rw = 1;
                2: fw = 1;
                3: ;
                4: br = 1'($urandom);
                5: begin rw = 1; ld = 1; end
                default: sw = 1;
            endcase
            drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 99;
            run_instr(rw, fw, ld, sw, 0, br, $urandom_range(0, 3), drop, cont);
        end
        if (cont) run_instr(0, 0, 0, 0, 0, 0, 0, 0, cont);
        run = 1'b0;
        #1;
        total++;
        if (halted !== 1'b1 || instr_count !== CW'(cnt_m)) begin
            bad++;
            $display("FAIL random_end: halted=%b cnt=%0d, want 1 %0d", halted, instr_count, CW'(cnt_m));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_run();
        test_mem();
        test_branch_step();
        test_stop();
        test_wrap();
        test_rst_in_mem();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
